// File: rtl/data_mem_bus.sv
// -----------------------------------------------------------------------------
// data_mem_bus
//
// Responder for the core's M-stage data-memory port. Each word-aligned byte
// address is decoded to either a word RAM (async read, sync write) or a small
// MMIO window holding an LED register and a free-running compare timer that
// can raise an interrupt.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   memwrite   write strobe; the access writes on this clk edge when high
//   aluout     byte address of the current access
//   writedata  store data (always a full word)
//   readdata   load data, combinational from aluout and current state
//   leds       LED register contents
//   irq        registered timer interrupt
//   bad_addr   sticky flag, set by any misaligned or unmapped access
//
// MMIO map (offsets from MMIO_BASE):
//   0x00 LED      R/W, low LED_W bits stored, reads zero-extended
//   0x04 COUNT    R/W, a write loads the counter
//   0x08 COMPARE  R/W
//   0x0C STATUS   bit0 MATCH, sticky, write-1-to-clear
//   0x10 CTRL     bits[2:0] = {IRQ_EN, AUTO_RELOAD, EN}
// -----------------------------------------------------------------------------
module data_mem_bus #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_8000,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      aluout,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] leds,
    output logic             irq,
    output logic             bad_addr
);

    localparam int ADDR_W = $clog2(4 * RAM_WORDS);
    localparam int IDX_W  = $clog2(RAM_WORDS);

    localparam logic [2:0] SEL_LED     = 3'd0;
    localparam logic [2:0] SEL_COUNT   = 3'd1;
    localparam logic [2:0] SEL_COMPARE = 3'd2;
    localparam logic [2:0] SEL_STATUS  = 3'd3;
    localparam logic [2:0] SEL_CTRL    = 3'd4;

    // Storage
    logic [31:0]      r_ram [RAM_WORDS];
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_match;
    logic [2:0]       r_ctrl;
    logic             r_irq;
    logic             r_bad;

    // Decode
    logic             w_aligned;
    logic             w_ram_hit;
    logic             w_mmio_hit;
    logic [IDX_W-1:0] w_ram_idx;
    logic [31:0]      w_mmio_off;
    logic [2:0]       w_sel;

    assign w_aligned  = (aluout[1:0] == 2'b00);
    // RAM_WORDS is a power of two, so "below 4*RAM_WORDS" is "upper bits zero".
    assign w_ram_hit  = w_aligned && (aluout[31:ADDR_W] == '0);
    assign w_ram_idx  = aluout[ADDR_W-1:2];
    assign w_mmio_off = aluout - MMIO_BASE;
    // The >= test guards against the subtraction wrapping for low addresses.
    assign w_mmio_hit = w_aligned && (aluout >= MMIO_BASE) && (w_mmio_off < 32'h14);
    assign w_sel      = w_mmio_off[4:2];

    logic w_wr_led, w_wr_count, w_wr_compare, w_wr_status, w_wr_ctrl;

    assign w_wr_led     = memwrite && w_mmio_hit && (w_sel == SEL_LED);
    assign w_wr_count   = memwrite && w_mmio_hit && (w_sel == SEL_COUNT);
    assign w_wr_compare = memwrite && w_mmio_hit && (w_sel == SEL_COMPARE);
    assign w_wr_status  = memwrite && w_mmio_hit && (w_sel == SEL_STATUS);
    assign w_wr_ctrl    = memwrite && w_mmio_hit && (w_sel == SEL_CTRL);

    // Timer next-state
    logic        w_en;
    logic        w_auto_reload;
    logic        w_match_now;
    logic [31:0] w_count_next;
    logic        w_match_next;
    logic [2:0]  w_ctrl_next;

    assign w_en          = r_ctrl[0];
    assign w_auto_reload = r_ctrl[1];
    // Match test uses the registered COMPARE, so a same-edge COMPARE write
    // only affects later edges.
    assign w_match_now   = w_en && (r_count == r_compare);

    always_comb begin
        w_count_next = r_count;
        if (w_en) begin
            if (w_match_now && w_auto_reload) begin
                w_count_next = 32'h0;
            end else begin
                w_count_next = r_count + 32'd1;
            end
        end
        // CPU load has the final say over increment and reload.
        if (w_wr_count) begin
            w_count_next = writedata;
        end
    end

    always_comb begin
        w_match_next = r_match;
        if (w_wr_status && writedata[0]) begin
            w_match_next = 1'b0;
        end
        // A new match outranks a same-edge clear.
        if (w_match_now) begin
            w_match_next = 1'b1;
        end
    end

    assign w_ctrl_next = w_wr_ctrl ? writedata[2:0] : r_ctrl;

    // Registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led     <= '0;
            r_count   <= 32'h0;
            r_compare <= 32'hFFFF_FFFF;
            r_match   <= 1'b0;
            r_ctrl    <= 3'b000;
            r_irq     <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_led <= writedata[LED_W-1:0];
            end
            if (w_wr_compare) begin
                r_compare <= writedata;
            end
            r_count <= w_count_next;
            r_match <= w_match_next;
            r_ctrl  <= w_ctrl_next;
            r_irq   <= w_match_next && w_ctrl_next[2];
            // The core has no read enable: every cycle is an access, and an
            // idle bus parks on a mapped address, so flag every unmapped cycle.
            if (!(w_ram_hit || w_mmio_hit)) begin
                r_bad <= 1'b1;
            end
        end
    end

    // RAM is not reset; it keeps its contents across reset pulses.
    always_ff @(posedge clk) begin
        if (memwrite && w_ram_hit) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    // Read mux
    always_comb begin
        readdata = 32'h0;
        if (w_ram_hit) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_sel)
                SEL_LED:     readdata[LED_W-1:0] = r_led;
                SEL_COUNT:   readdata = r_count;
                SEL_COMPARE: readdata = r_compare;
                SEL_STATUS:  readdata[0] = r_match;
                SEL_CTRL:    readdata[2:0] = r_ctrl;
                default:     readdata = 32'h0;
            endcase
        end
    end

    assign leds     = r_led;
    assign irq      = r_irq;
    assign bad_addr = r_bad;

endmodule

// File: tb/tb_data_mem_bus.sv
module tb_data_mem_bus;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] leds;
    logic        irq;
    logic        bad_addr;

    int n_vec  = 0;
    int n_fail = 0;

    data_mem_bus #(
        .RAM_WORDS (1024),
        .MMIO_BASE (32'h0000_8000),
        .LED_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .irq       (irq),
        .bad_addr  (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        rst_before;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_leds;
        logic        exp_bad;
        string       name;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end else begin
            $display("ok   %s: %08h", nm, act);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite  = we;
        aluout    = a;
        writedata = d;
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after an edge; reset is low well clear of both edges.
    task automatic pulse_reset();
        bus(1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus(1'b0, 32'h0, 32'h0);

        //        rst we  addr          wdata         chk rd            leds      bad
        vecs[0]  = '{0, 1, 32'h0000_0014, 32'h1234_5678, 0, 32'h0,          16'h0,    0, "wr_ram14"};
        vecs[1]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,          16'h0,    0, "wr_ram10"};
        vecs[2]  = '{0, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0, "rd_ram10"};
        vecs[3]  = '{0, 0, 32'h0000_0014, 32'h0,         1, 32'h1234_5678,  16'h0,    0, "rd_ram14"};
        vecs[4]  = '{0, 1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0,          16'h0,    0, "wr_ram0"};
        vecs[5]  = '{0, 1, 32'h0000_8000, 32'h0001_A5A5, 1, 32'h0,          16'hA5A5, 0, "wr_led"};
        vecs[6]  = '{0, 0, 32'h0000_8000, 32'h0,         1, 32'h0000_A5A5,  16'hA5A5, 0, "rd_led"};
        vecs[7]  = '{0, 0, 32'h0000_8008, 32'h0,         1, 32'hFFFF_FFFF,  16'hA5A5, 0, "rd_cmp_rst"};
        vecs[8]  = '{0, 0, 32'h0000_8004, 32'h0,         1, 32'h0,          16'hA5A5, 0, "rd_cnt_rst"};
        vecs[9]  = '{0, 0, 32'h0000_800C, 32'h0,         1, 32'h0,          16'hA5A5, 0, "rd_status_rst"};
        vecs[10] = '{0, 1, 32'h0000_8010, 32'hFFFF_FFF8, 1, 32'h0,          16'hA5A5, 0, "wr_ctrl_hi"};
        vecs[11] = '{0, 0, 32'h0000_8010, 32'h0,         1, 32'h0,          16'hA5A5, 0, "rd_ctrl_mask"};
        vecs[12] = '{0, 1, 32'h0000_0002, 32'h0000_0099, 1, 32'h0,          16'hA5A5, 1, "wr_misaligned"};
        vecs[13] = '{0, 0, 32'h0000_0000, 32'h0,         1, 32'h1111_1111,  16'hA5A5, 1, "rd_ram0_kept"};
        vecs[14] = '{1, 0, 32'h0001_0000, 32'h0,         1, 32'h0,          16'h0,    1, "rd_unmapped"};
        vecs[15] = '{1, 0, 32'h0000_8014, 32'h0,         1, 32'h0,          16'h0,    1, "rd_past_mmio"};
        vecs[16] = '{1, 0, 32'h0000_8012, 32'h0,         1, 32'h0,          16'h0,    1, "rd_mmio_misal"};
        vecs[17] = '{1, 0, 32'h0000_0FFC, 32'h0,         0, 32'h0,          16'h0,    0, "rd_ram_top"};
        vecs[18] = '{1, 0, 32'h0000_1000, 32'h0,         1, 32'h0,          16'h0,    1, "rd_past_ram"};
        vecs[19] = '{1, 1, 32'h0000_8014, 32'h0000_0005, 1, 32'h0,          16'h0,    1, "wr_unmapped"};

        // Reset state, checked while reset is still held.
        #12;
        chk("rst_leds", {16'h0, leds}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_bad", {31'h0, bad_addr}, 32'h0);
        reset = 1'b1;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst_before) pulse_reset();
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            if (vecs[i].chk_rd) chk({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
            tick();
            chk({vecs[i].name, "_leds"}, {16'h0, leds}, {16'h0, vecs[i].exp_leds});
            chk({vecs[i].name, "_bad"}, {31'h0, bad_addr}, {31'h0, vecs[i].exp_bad});
        end

        // Auto-reload with interrupt: COMPARE=5, CTRL=111.
        pulse_reset();
        bus(1'b1, 32'h8008, 32'd5); tick();
        bus(1'b1, 32'h8010, 32'd7); tick();
        bus(1'b0, 32'h8004, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t1_count", readdata, (k < 6) ? 32'(k) : 32'd0);
            chk("t1_irq", {31'h0, irq}, (k == 6) ? 32'd1 : 32'd0);
        end
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t1_status_set", readdata, 32'd1);
        bus(1'b1, 32'h800C, 32'd1); tick();
        chk("t1_irq_cleared", {31'h0, irq}, 32'd0);
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t1_status_clr", readdata, 32'd0);
        bus(1'b0, 32'h8004, 32'd0); #1;
        chk("t1_count_after_clr", readdata, 32'd1);
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("t1_rematch_irq", {31'h0, irq}, (j == 5) ? 32'd1 : 32'd0);
        end

        // Wrap without reload, IRQ_EN=0.
        pulse_reset();
        bus(1'b1, 32'h8004, 32'hFFFF_FFFE); tick();
        bus(1'b1, 32'h8008, 32'd3); tick();
        bus(1'b1, 32'h8010, 32'd1); tick();
        bus(1'b0, 32'h8004, 32'd0);
        begin
            logic [31:0] exp_cnt [7];
            exp_cnt = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
            for (int i = 0; i < 7; i++) begin
                tick();
                chk("t2_count", readdata, exp_cnt[i]);
                chk("t2_irq", {31'h0, irq}, 32'd0);
            end
        end
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t2_status", readdata, 32'd1);

        // Simultaneous events.
        pulse_reset();
        bus(1'b1, 32'h8008, 32'd2); tick();
        bus(1'b1, 32'h8010, 32'd1); tick();
        bus(1'b0, 32'h8004, 32'd0); tick(); tick();
        bus(1'b1, 32'h800C, 32'd1); tick();   // match edge coincides with clear
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t3_set_wins", readdata, 32'd1);
        bus(1'b0, 32'h8004, 32'd0); #1;
        chk("t3_count_reload_off", readdata, 32'd3);
        bus(1'b1, 32'h8004, 32'h0000_0100); tick();
        bus(1'b0, 32'h8004, 32'd0); #1;
        chk("t3_count_write_wins", readdata, 32'h0000_0100);
        bus(1'b1, 32'h800C, 32'd0); tick();
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t3_status_w0_noop", readdata, 32'd1);
        chk("t3_irq_disabled", {31'h0, irq}, 32'd0);

        // Asynchronous reset mid-count.
        pulse_reset();
        bus(1'b1, 32'h8000, 32'h0000_FFFF); tick();
        bus(1'b1, 32'h8008, 32'd3); tick();
        bus(1'b1, 32'h8010, 32'd7); tick();
        bus(1'b0, 32'h8004, 32'd0);
        for (int k = 0; k < 5; k++) tick();
        bus(1'b0, 32'h0002_0000, 32'd0); tick();
        chk("t4_pre_irq", {31'h0, irq}, 32'd1);
        chk("t4_pre_bad", {31'h0, bad_addr}, 32'd1);
        chk("t4_pre_leds", {16'h0, leds}, 32'h0000_FFFF);
        reset = 1'b0;
        bus(1'b0, 32'h8004, 32'd0); #1;
        chk("t4_rst_count", readdata, 32'd0);
        chk("t4_rst_irq", {31'h0, irq}, 32'd0);
        chk("t4_rst_bad", {31'h0, bad_addr}, 32'd0);
        chk("t4_rst_leds", {16'h0, leds}, 32'd0);
        bus(1'b0, 32'h8008, 32'd0); #1;
        chk("t4_rst_compare", readdata, 32'hFFFF_FFFF);
        bus(1'b0, 32'h8010, 32'd0); #1;
        chk("t4_rst_ctrl", readdata, 32'd0);
        bus(1'b0, 32'h800C, 32'd0); #1;
        chk("t4_rst_status", readdata, 32'd0);
        reset = 1'b1;
        bus(1'b0, 32'h0000_0010, 32'd0); #1;
        chk("t4_ram_kept", readdata, 32'hDEAD_BEEF);
        tick();
        chk("t4_idle_no_bad", {31'h0, bad_addr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
